// File: rtl/pdp8_pkg.sv
// Shared PDP-8 widths, read-pipeline stage payload, trace channel ids and counter helper.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

    localparam int unsigned ADDR_W     = `ADDR_WIDTH;
    localparam int unsigned DATA_W     = `DATA_WIDTH;
    localparam int unsigned MAX_RD_LAT = 8;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        CH_IFU,
        CH_EXR,
        CH_EXW
    } trace_ch_t;

    typedef struct packed {
        logic                   valid;
        logic [`DATA_WIDTH-1:0] data;
    } rd_stage_t;

    // Add 0..3 to a counter, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

`ifdef PDP8_MEM_TRACE_EN
    function automatic string ch_tag(input trace_ch_t ch);
        case (ch)
            CH_IFU:  return "IFU";
            CH_EXR:  return "EXR";
            default: return "EXW";
        endcase
    endfunction
`endif

endpackage

// File: rtl/pdp8_rd_pipe.sv
// RD_LAT-deep valid/data delay line; data in each stage only moves when its source is valid,
// so the output word holds its last value while valid is low.
module pdp8_rd_pipe
    import pdp8_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  rd_stage_t         in_stage,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    for (genvar g = 0; g < RD_LAT; g++) begin : g_stage
        rd_stage_t src;
        rd_stage_t q;

        if (g == 0) begin : g_head
            assign src = in_stage;
        end else begin : g_tail
            assign src = g_stage[g-1].q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q <= '0;
            end else begin
                q.valid <= src.valid;
                if (src.valid) begin
                    q.data <= src.data;
                end
            end
        end
    end

    assign out_valid = g_stage[RD_LAT-1].q.valid;
    assign out_data  = g_stage[RD_LAT-1].q.data;

endmodule

// File: rtl/pdp8_mem_responder.sv
// PDP-8 memory responder: word array with IFU and exec read channels, exec write channel.
// Optional PDP8_MEM_TRACE_EN compiles in a per-access $display trace.
module pdp8_mem_responder
    import pdp8_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W,
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned INIT_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_rd_valid,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  exec_wr_ack,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      wr_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DATA_WIDTH != DATA_W) begin : g_bad_width
        $error("pdp8_mem_responder: DATA_WIDTH must equal the pdp8_pkg data width");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH > (32'd1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("pdp8_mem_responder: DEPTH must be a power of 2 no larger than 2**ADDR_WIDTH");
    end
    if (RD_LAT == 0 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
        $error("pdp8_mem_responder: RD_LAT must be in 1..MAX_RD_LAT");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      ifu_idx;
    logic [IDX_W-1:0]      exr_idx;
    logic [IDX_W-1:0]      exw_idx;
    logic [DATA_WIDTH-1:0] ifu_word;
    logic [DATA_WIDTH-1:0] exr_word;
    rd_stage_t             ifu_stage;
    rd_stage_t             exr_stage;

    // Upper address bits are masked off so accesses wrap modulo DEPTH.
    assign ifu_idx = IDX_W'(ifu_rd_addr  & ADDR_WIDTH'(DEPTH - 1));
    assign exr_idx = IDX_W'(exec_rd_addr & ADDR_WIDTH'(DEPTH - 1));
    assign exw_idx = IDX_W'(exec_wr_addr & ADDR_WIDTH'(DEPTH - 1));

    // Write-first: a same-edge write to the read index bypasses straight to the read.
    always_comb begin
        ifu_word = mem[ifu_idx];
        exr_word = mem[exr_idx];
        if (exec_wr_req && (exw_idx == ifu_idx)) begin
            ifu_word = exec_wr_data;
        end
        if (exec_wr_req && (exw_idx == exr_idx)) begin
            exr_word = exec_wr_data;
        end
    end

    assign ifu_stage.valid = ifu_rd_req;
    assign ifu_stage.data  = ifu_word;
    assign exr_stage.valid = exec_rd_req;
    assign exr_stage.data  = exr_word;

    // Word array, reloaded with the reset image whenever reset_n is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[IDX_W'(i)] <= (INIT_MODE == 0) ? DATA_WIDTH'(i) : '0;
            end
        end else if (exec_wr_req) begin
            mem[exw_idx] <= exec_wr_data;
        end
    end

    pdp8_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_ifu_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_stage  (ifu_stage),
        .out_valid (ifu_rd_valid),
        .out_data  (ifu_rd_data)
    );

    pdp8_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_exr_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_stage  (exr_stage),
        .out_valid (exec_rd_valid),
        .out_data  (exec_rd_data)
    );

    // Write acknowledge and saturating access counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_wr_ack <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
        end else begin
            exec_wr_ack <= exec_wr_req;
            rd_count    <= sat_add(rd_count, 2'(ifu_rd_req) + 2'(exec_rd_req));
            wr_count    <= sat_add(wr_count, 2'(exec_wr_req));
        end
    end

`ifdef PDP8_MEM_TRACE_EN
    logic [ADDR_WIDTH-1:0] ifu_trace_addr [RD_LAT];
    logic [ADDR_WIDTH-1:0] exr_trace_addr [RD_LAT];

    // Address shadow of the read pipelines so returns can be traced with their address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                ifu_trace_addr[i] <= '0;
                exr_trace_addr[i] <= '0;
            end
        end else begin
            ifu_trace_addr[0] <= ifu_rd_addr;
            exr_trace_addr[0] <= exec_rd_addr;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                ifu_trace_addr[i] <= ifu_trace_addr[i-1];
                exr_trace_addr[i] <= exr_trace_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (ifu_rd_valid) begin
                $display("%0t %s addr=%o data=%o", $time, ch_tag(CH_IFU),
                         ifu_trace_addr[RD_LAT-1], ifu_rd_data);
            end
            if (exec_rd_valid) begin
                $display("%0t %s addr=%o data=%o", $time, ch_tag(CH_EXR),
                         exr_trace_addr[RD_LAT-1], exec_rd_data);
            end
            if (exec_wr_req) begin
                $display("%0t %s addr=%o data=%o", $time, ch_tag(CH_EXW),
                         exec_wr_addr, exec_wr_data);
            end
            if (exec_wr_req && ((ifu_rd_req && ifu_idx == exw_idx) ||
                                (exec_rd_req && exr_idx == exw_idx))) begin
                $display("%0t RAW-BYPASS addr=%o data=%o", $time, exec_wr_addr, exec_wr_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pdp8_mem_responder.sv
// Bench for pdp8_mem_responder: two configurations driven by directed and random steps,
// checked against a due-time scoreboard model of the memory.
module tb_pdp8_mem_responder;

    localparam int NDUT = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    [NDUT];
    logic        ifu_req  [NDUT];
    logic        exr_req  [NDUT];
    logic        exw_req  [NDUT];
    logic [11:0] ifu_addr [NDUT];
    logic [11:0] exr_addr [NDUT];
    logic [11:0] exw_addr [NDUT];
    logic [11:0] exw_data [NDUT];
    logic [11:0] ifu_data [NDUT];
    logic [11:0] exr_data [NDUT];
    logic        ifu_vld  [NDUT];
    logic        exr_vld  [NDUT];
    logic        wr_ack   [NDUT];
    logic [15:0] rd_cnt   [NDUT];
    logic [15:0] wr_cnt   [NDUT];

    pdp8_mem_responder #(
        .ADDR_WIDTH (12), .DATA_WIDTH (12), .DEPTH (4096), .RD_LAT (1), .INIT_MODE (0)
    ) dut_a (
        .clk (clk), .reset_n (rst_n[0]),
        .ifu_rd_req (ifu_req[0]), .ifu_rd_addr (ifu_addr[0]),
        .ifu_rd_data (ifu_data[0]), .ifu_rd_valid (ifu_vld[0]),
        .exec_rd_req (exr_req[0]), .exec_rd_addr (exr_addr[0]),
        .exec_rd_data (exr_data[0]), .exec_rd_valid (exr_vld[0]),
        .exec_wr_req (exw_req[0]), .exec_wr_addr (exw_addr[0]),
        .exec_wr_data (exw_data[0]), .exec_wr_ack (wr_ack[0]),
        .rd_count (rd_cnt[0]), .wr_count (wr_cnt[0])
    );

    pdp8_mem_responder #(
        .ADDR_WIDTH (12), .DATA_WIDTH (12), .DEPTH (1024), .RD_LAT (4), .INIT_MODE (0)
    ) dut_b (
        .clk (clk), .reset_n (rst_n[1]),
        .ifu_rd_req (ifu_req[1]), .ifu_rd_addr (ifu_addr[1]),
        .ifu_rd_data (ifu_data[1]), .ifu_rd_valid (ifu_vld[1]),
        .exec_rd_req (exr_req[1]), .exec_rd_addr (exr_addr[1]),
        .exec_rd_data (exr_data[1]), .exec_rd_valid (exr_vld[1]),
        .exec_wr_req (exw_req[1]), .exec_wr_addr (exw_addr[1]),
        .exec_wr_data (exw_data[1]), .exec_wr_ack (wr_ack[1]),
        .rd_count (rd_cnt[1]), .wr_count (wr_cnt[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 0) ? 4096 : 1024;
    endfunction

    // Reference model: word array plus per-channel expected returns keyed by due edge.
    logic [11:0] m_mem  [NDUT][4096];
    int          m_rd   [NDUT];
    int          m_wr   [NDUT];
    logic        m_ack  [NDUT];
    logic        m_ov   [NDUT][2];
    logic [11:0] m_last [NDUT][2];
    logic        m_pv   [NDUT][2][16];
    logic [11:0] m_pd   [NDUT][2][16];
    int          edge_n = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < 4096; i++) m_mem[d][i] = 12'(i);
        m_rd[d]  = 0;
        m_wr[d]  = 0;
        m_ack[d] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            m_ov[d][c]   = 1'b0;
            m_last[d][c] = 12'h000;
            for (int s = 0; s < 16; s++) m_pv[d][c][s] = 1'b0;
        end
    endtask

    task automatic model_edge(input int d);
        int dep, due, slot, wi, ri, ei;
        if (!rst_n[d]) return;
        dep  = depth_of(d);
        due  = (edge_n + lat_of(d) - 1) % 16;
        slot = edge_n % 16;
        wi   = int'(exw_addr[d]) % dep;
        ri   = int'(ifu_addr[d]) % dep;
        ei   = int'(exr_addr[d]) % dep;
        if (ifu_req[d]) begin
            m_pv[d][0][due] = 1'b1;
            m_pd[d][0][due] = (exw_req[d] && wi == ri) ? exw_data[d] : m_mem[d][ri];
        end
        if (exr_req[d]) begin
            m_pv[d][1][due] = 1'b1;
            m_pd[d][1][due] = (exw_req[d] && wi == ei) ? exw_data[d] : m_mem[d][ei];
        end
        if (exw_req[d]) m_mem[d][wi] = exw_data[d];
        m_ack[d] = exw_req[d];
        m_rd[d]  = m_rd[d] + int'(ifu_req[d]) + int'(exr_req[d]);
        m_wr[d]  = m_wr[d] + int'(exw_req[d]);
        if (m_rd[d] > 65535) m_rd[d] = 65535;
        if (m_wr[d] > 65535) m_wr[d] = 65535;
        for (int c = 0; c < 2; c++) begin
            m_ov[d][c] = m_pv[d][c][slot];
            if (m_ov[d][c]) m_last[d][c] = m_pd[d][c][slot];
            m_pv[d][c][slot] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("d%0d_ifu_vld", d),  32'(ifu_vld[d]), 32'(m_ov[d][0]));
            chk($sformatf("d%0d_ifu_data", d), 32'(ifu_data[d]), 32'(m_last[d][0]));
            chk($sformatf("d%0d_exr_vld", d),  32'(exr_vld[d]), 32'(m_ov[d][1]));
            chk($sformatf("d%0d_exr_data", d), 32'(exr_data[d]), 32'(m_last[d][1]));
            chk($sformatf("d%0d_wr_ack", d),   32'(wr_ack[d]),  32'(m_ack[d]));
            chk($sformatf("d%0d_rd_cnt", d),   32'(rd_cnt[d]),  32'(m_rd[d]));
            chk($sformatf("d%0d_wr_cnt", d),   32'(wr_cnt[d]),  32'(m_wr[d]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) model_edge(d);
        edge_n++;
        #1;
        check_all();
    endtask

    task automatic idle(input int d);
        ifu_req[d] = 1'b0;
        exr_req[d] = 1'b0;
        exw_req[d] = 1'b0;
    endtask

    task automatic set_reset(input int d, input logic v);
        rst_n[d] = v;
        if (!v) model_reset(d);
    endtask

    function automatic logic [11:0] rnd_addr();
        logic [11:0] a;
        a = 12'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a = a ^ 12'h400;
        return a;
    endfunction

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            idle(d);
            ifu_addr[d] = '0;
            exr_addr[d] = '0;
            exw_addr[d] = '0;
            exw_data[d] = '0;
            set_reset(d, 1'b0);
        end
        ifu_req[0] = 1'b1;
        step();
        step();
        idle(0);
        for (int d = 0; d < NDUT; d++) set_reset(d, 1'b1);
        step();

        // Reset image read.
        ifu_req[0] = 1'b1; ifu_addr[0] = 12'o0017;
        step();
        idle(0);
        chk("img_vld", 32'(ifu_vld[0]), 32'd1);
        chk("img_data", 32'(ifu_data[0]), 32'o0017);
        chk("img_rd_cnt", 32'(rd_cnt[0]), 32'd1);
        step();
        chk("img_vld_drop", 32'(ifu_vld[0]), 32'd0);
        chk("img_data_hold", 32'(ifu_data[0]), 32'o0017);

        // Write then read.
        exw_req[0] = 1'b1; exw_addr[0] = 12'o0200; exw_data[0] = 12'o7777;
        step();
        idle(0);
        chk("wr_ack", 32'(wr_ack[0]), 32'd1);
        chk("wr_cnt", 32'(wr_cnt[0]), 32'd1);
        exr_req[0] = 1'b1; exr_addr[0] = 12'o0200;
        step();
        idle(0);
        chk("wr_ack_drop", 32'(wr_ack[0]), 32'd0);
        chk("wr_rd_data", 32'(exr_data[0]), 32'o7777);

        // Same-edge write and two reads of one index.
        exw_req[0] = 1'b1; exw_addr[0] = 12'o0050; exw_data[0] = 12'o1234;
        ifu_req[0] = 1'b1; ifu_addr[0] = 12'o0050;
        exr_req[0] = 1'b1; exr_addr[0] = 12'o0050;
        step();
        idle(0);
        chk("raw_ifu", 32'(ifu_data[0]), 32'o1234);
        chk("raw_exr", 32'(exr_data[0]), 32'o1234);
        chk("raw_rd_cnt", 32'(rd_cnt[0]), 32'd4);
        step();

        // Latency 4, three back-to-back reads.
        for (int c = 1; c <= 7; c++) begin
            if (c <= 3) begin
                exr_req[1] = 1'b1; exr_addr[1] = 12'(c);
            end else begin
                exr_req[1] = 1'b0;
            end
            step();
            chk($sformatf("lat_vld_c%0d", c), 32'(exr_vld[1]), 32'((c >= 4 && c <= 6) ? 1 : 0));
            if (c >= 4 && c <= 6) chk($sformatf("lat_data_c%0d", c), 32'(exr_data[1]), 32'(c - 3));
        end

        // Address wrap at DEPTH=1024.
        exw_req[1] = 1'b1; exw_addr[1] = 12'o2005; exw_data[1] = 12'o0055;
        step();
        idle(1);
        exr_req[1] = 1'b1; exr_addr[1] = 12'o0005;
        step();
        idle(1);
        for (int i = 0; i < 3; i++) step();
        chk("wrap_vld", 32'(exr_vld[1]), 32'd1);
        chk("wrap_data", 32'(exr_data[1]), 32'o0055);

        // Reset while a read is in flight.
        ifu_req[1] = 1'b1; ifu_addr[1] = 12'o0005;
        step();
        idle(1);
        step();
        set_reset(1, 1'b0);
        #1;
        check_all();
        chk("rst_rd_cnt", 32'(rd_cnt[1]), 32'd0);
        chk("rst_wr_cnt", 32'(wr_cnt[1]), 32'd0);
        step();
        set_reset(1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rst_drop_%0d", i), 32'(ifu_vld[1]), 32'd0);
        end
        exr_req[1] = 1'b1; exr_addr[1] = 12'o0005;
        step();
        idle(1);
        for (int i = 0; i < 3; i++) step();
        chk("rst_img_data", 32'(exr_data[1]), 32'o0005);

        // Random traffic on both configurations.
        for (int i = 0; i < 600; i++) begin
            for (int d = 0; d < NDUT; d++) begin
                ifu_req[d]  = 1'($urandom_range(0, 1));
                exr_req[d]  = 1'($urandom_range(0, 1));
                exw_req[d]  = 1'($urandom_range(0, 1));
                ifu_addr[d] = rnd_addr();
                exr_addr[d] = rnd_addr();
                exw_addr[d] = rnd_addr();
                exw_data[d] = 12'($urandom);
            end
            step();
        end
        for (int d = 0; d < NDUT; d++) idle(d);
        for (int i = 0; i < 6; i++) step();

        // Read counter saturation.
        ifu_req[1] = 1'b1;
        exr_req[1] = 1'b1;
        for (int i = 0; i < 32770; i++) begin
            ifu_addr[1] = 12'($urandom);
            exr_addr[1] = 12'($urandom);
            step();
        end
        idle(1);
        chk("rd_sat", 32'(rd_cnt[1]), 32'hFFFF);
        for (int i = 0; i < 6; i++) step();
        chk("rd_sat_hold", 32'(rd_cnt[1]), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
